dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//  Data-side responder for the single-cycle MIPS core. Combinational-read, clocked-write word RAM.
//  Decodes a 16-byte MMIO window holding a console TX FIFO, a halt flag and a RAM write counter.
//  Sits where the plain data memory sits: driven by memwrite/dataaddr/writedata, returns readdata.
//  Drains console bytes to an external consumer over a valid/ready port.
// PARAMETERS
//  DEPTH_WORDS  64             RAM depth in 32-bit words, power of 2
//  FIFO_DEPTH   8              console FIFO entries, power of 2, <=128
//  MMIO_BASE    32'hFFFF_FF00  base of MMIO window; bits [3:0] must be 0
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  we           in   1   write strobe from core (memwrite)
//  addr         in   32  byte address from core (dataaddr); addr[1:0] ignored
//  writedata    in   32  store data from core
//  readdata     out  32  load data to core, combinational
//  tx_data      out  8   FIFO head byte
//  tx_valid     out  1   FIFO non-empty
//  tx_ready     in   1   consumer accepts tx_data this cycle
//  halt         out  1   sticky halt flag, set by program
//  write_count  out  32  number of accepted RAM writes since reset
// BEHAVIOUR
//  Decode: mmio = (addr[31:4] == MMIO_BASE[31:4]); reg = addr[3:2]; otherwise RAM index = addr[2+:log2(DEPTH_WORDS)].
//  RAM is modulo-aliased: upper address bits are ignored.
//  RAM write: at posedge when we && !mmio; write_count += 1, wrapping 2^32-1 -> 0.
//  RAM read: readdata = ram[index] combinationally. Same-cycle write: old data is read; new data is visible next cycle.
//  RAM contents are NOT cleared by reset; the simulation init is all zeros.
//  MMIO map (word offset, by reg):
//   0 TXDATA  W: push writedata[7:0]; R: 0
//   1 STATUS  R only: [0]empty [1]full [2]overflow [3]halt [15:8]fifo count, other bits 0; W ignored
//   2 HALT    W: halt<=1 (any data); R: {31'b0,halt}
//   3 COUNT   R: write_count; W: write_count<=0 (clear wins over nothing; MMIO writes never increment)
//  FIFO: circular buffer, rd/wr pointers with extra wrap bit, count 0..FIFO_DEPTH.
//   pop  = tx_valid && tx_ready.
//   push = we && mmio && reg==0.
//   Push is accepted iff count<FIFO_DEPTH || pop in the same cycle.
//   A rejected push sets the overflow bit (sticky until reset); the byte is dropped and pointers are unchanged.
//   Push+pop in one cycle: count unchanged, both pointers advance. Pop when empty is impossible (tx_valid=0).
//   tx_data = mem[rd_ptr]. It is stable while tx_valid && !tx_ready. It is undefined (hold last) when empty.
//  halt: once set, stays 1 until reset. It does not block RAM or FIFO activity.
//  Reset (any cycle, including mid-drain):
//   FIFO pointers/count=0, so tx_valid=0 on the next cycle.
//   overflow=0, halt=0, write_count=0. readdata still reflects RAM.
//   A push/write in the reset cycle is discarded (reset has priority).
//  Latency: load 0 cycles; store/push visible 1 cycle after the posedge; tx_valid rises 1 cycle after the push edge.
// TESTING
//  1 Reset, tx_ready=1 -> tx_valid=0, halt=0, write_count=0, STATUS read = 32'h0000_0001.
//  2 Write 7 @84, then write 9 @84+4*DEPTH_WORDS -> read @84 = 9 (alias); write_count=2; COUNT read=2.
//  3 tx_ready=0; push 'H','i','!' -> STATUS count=3.
//    Then tx_ready=1 -> tx_data 8'h48,8'h69,8'h21 on consecutive cycles, then tx_valid=0.
//  4 tx_ready=0; push 9 bytes 0..8 -> full=1, overflow=1, count=8.
//    Drain yields 0..7 only; overflow stays 1 after the drain.
//  5 FIFO full, tx_ready=1 and push 8'hAA same cycle -> accepted, count stays 8, overflow stays 0, AA emerges last.
//  6 3 bytes queued, tx_ready toggling, assert reset 1 cycle mid-drain with a concurrent push
//    -> next cycle tx_valid=0, count=0; write HALT -> halt=1 until next reset.

Source files
------------

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_mmio
//  Brief   : Word RAM with combinational read / clocked write, plus a 16-byte
//            MMIO window (console TX FIFO, halt flag, RAM write counter).
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_mmio #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt,
   output logic [31:0] write_count
);

   localparam int c_AW = $clog2(DEPTH_WORDS);
   localparam int c_PW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] c_REG_TXDATA = 2'd0;
   localparam logic [1:0] c_REG_STATUS = 2'd1;
   localparam logic [1:0] c_REG_HALT   = 2'd2;
   localparam logic [1:0] c_REG_COUNT  = 2'd3;

   logic [31:0]     r_ram  [DEPTH_WORDS];
   logic [7:0]      r_fifo [FIFO_DEPTH];
   logic [c_PW:0]   r_wr_ptr;
   logic [c_PW:0]   r_rd_ptr;
   logic            r_overflow;
   logic            r_halt;
   logic [31:0]     r_write_count;

   logic            w_mmio;
   logic [1:0]      w_reg;
   logic [c_AW-1:0] w_idx;
   logic            w_ram_wr;
   logic            w_mmio_wr;
   logic            w_push;
   logic            w_pop;
   logic            w_push_ok;
   logic            w_push_rej;
   logic            w_empty;
   logic            w_full;
   logic [c_PW:0]   w_count;
   logic [7:0]      w_cnt8;
   logic [31:0]     w_status;
   logic            w_unused;

   assign w_mmio    = (addr[31:4] == MMIO_BASE[31:4]);
   assign w_reg     = addr[3:2];
   assign w_idx     = addr[2 +: c_AW];
   assign w_ram_wr  = we & ~w_mmio;
   assign w_mmio_wr = we & w_mmio;
   assign w_unused  = ^addr[1:0];

   // Extra wrap bit on the pointers distinguishes full from empty.
   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                       (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
   assign w_push     = w_mmio_wr && (w_reg == c_REG_TXDATA);
   assign w_pop      = ~w_empty & tx_ready;
   assign w_push_ok  = w_push & (~w_full | w_pop);
   assign w_push_rej = w_push & w_full & ~w_pop;
   assign w_cnt8     = 8'(w_count);
   assign w_status   = {16'h0000, w_cnt8, 4'h0, r_halt, r_overflow, w_full, w_empty};

   always_ff @(posedge clk) begin
      if (!reset && w_ram_wr)
         r_ram[w_idx] <= writedata;
   end

   // A full FIFO popped this cycle frees the slot being written.
   always_ff @(posedge clk) begin
      if (!reset && w_push_ok)
         r_fifo[r_wr_ptr[c_PW-1:0]] <= writedata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_overflow    <= 1'b0;
         r_halt        <= 1'b0;
         r_write_count <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_rej)
            r_overflow <= 1'b1;
         if (w_mmio_wr && (w_reg == c_REG_HALT))
            r_halt <= 1'b1;
         if (w_mmio_wr && (w_reg == c_REG_COUNT))
            r_write_count <= '0;
         else if (w_ram_wr)
            r_write_count <= r_write_count + 32'd1;
      end
   end

   always_comb begin
      readdata = r_ram[w_idx];
      if (w_mmio) begin
         case (w_reg)
            c_REG_TXDATA: readdata = 32'h0;
            c_REG_STATUS: readdata = w_status;
            c_REG_HALT:   readdata = {31'h0, r_halt};
            c_REG_COUNT:  readdata = r_write_count;
            default:      readdata = 32'h0;
         endcase
      end
   end

   assign tx_data     = r_fifo[r_rd_ptr[c_PW-1:0]];
   assign tx_valid    = ~w_empty;
   assign halt        = r_halt;
   assign write_count = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_mmio
//  Brief   : Directed and random bench for dmem_mmio against a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_mmio;

   localparam int          c_DEPTH = 64;
   localparam int          c_FDEP  = 8;
   localparam logic [31:0] c_BASE  = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        halt;
   logic [31:0] write_count;

   int n_chk = 0;
   int n_err = 0;

   // Reference state
   logic [31:0] m_ram   [c_DEPTH];
   bit          m_known [c_DEPTH];
   logic [7:0]  m_q [$];
   bit          m_ovf;
   bit          m_halt;
   logic [31:0] m_wc;

   always #5 clk = ~clk;

   dmem_mmio #(.DEPTH_WORDS(c_DEPTH), .FIFO_DEPTH(c_FDEP), .MMIO_BASE(c_BASE)) u_dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .writedata(writedata),
      .readdata(readdata), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .halt(halt), .write_count(write_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int n;
      n = m_q.size();
      if (a[31:4] == c_BASE[31:4]) begin
         case (a[3:2])
            2'd1:    return {16'h0, 8'(n), 4'h0, m_halt, m_ovf, (n == c_FDEP), (n == 0)};
            2'd2:    return {31'h0, m_halt};
            2'd3:    return m_wc;
            default: return 32'h0;
         endcase
      end
      return m_ram[a[7:2]];
   endfunction

   // Apply inputs, let them settle, compare against the model (before the edge).
   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic rst);
      we = w; addr = a; writedata = d; tx_ready = rdy; reset = rst;
      #4;
      check("txv", {31'h0, tx_valid}, {31'h0, m_q.size() > 0});
      if (m_q.size() > 0)
         check("txd", {24'h0, tx_data}, {24'h0, m_q[0]});
      check("halt", {31'h0, halt}, {31'h0, m_halt});
      check("wcnt", write_count, m_wc);
      if ((a[31:4] == c_BASE[31:4]) || m_known[a[7:2]])
         check("rdata", readdata, m_read(a));
   endtask

   // Clock edge, then advance the model by the rules for that edge.
   task automatic tick();
      bit pop, mmio;
      @(posedge clk);
      if (reset) begin
         m_q.delete(); m_ovf = 0; m_halt = 0; m_wc = 0;
      end else begin
         pop  = (m_q.size() > 0) && tx_ready;
         mmio = (addr[31:4] == c_BASE[31:4]);
         if (we && !mmio) begin
            m_ram[addr[7:2]] = writedata; m_known[addr[7:2]] = 1; m_wc = m_wc + 1;
         end
         if (pop) void'(m_q.pop_front());
         if (we && mmio) begin
            case (addr[3:2])
               2'd0: if (m_q.size() < c_FDEP) m_q.push_back(writedata[7:0]); else m_ovf = 1;
               2'd2: m_halt = 1;
               2'd3: m_wc = 0;
               default: ;
            endcase
         end
      end
      #1;
   endtask

   task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic rst);
      drive(w, a, d, rdy, rst);
      tick();
   endtask

   localparam logic [31:0] c_TX  = 32'hFFFF_FF00;
   localparam logic [31:0] c_ST  = 32'hFFFF_FF04;
   localparam logic [31:0] c_HLT = 32'hFFFF_FF08;
   localparam logic [31:0] c_CNT = 32'hFFFF_FF0C;

   initial begin
      logic [7:0]  hi [3];
      logic [31:0] a;
      for (int i = 0; i < c_DEPTH; i++) begin m_ram[i] = '0; m_known[i] = 0; end
      m_ovf = 0; m_halt = 0; m_wc = 0;
      hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h21;
      we = 0; addr = 0; writedata = 0; tx_ready = 1; reset = 1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      drive(0, c_ST, 0, 1, 0);
      check("rst_status", readdata, 32'h0000_0001);
      check("rst_txv", {31'h0, tx_valid}, 32'h0);
      tick();

      // Aliasing and write counter
      cyc(1, 32'd84, 32'd7, 1, 0);
      cyc(1, 32'd84 + 4 * c_DEPTH, 32'd9, 1, 0);
      drive(0, 32'd84, 0, 1, 0);
      check("alias", readdata, 32'd9);
      check("wc2", write_count, 32'd2);
      tick();
      drive(0, c_CNT, 0, 1, 0);
      check("count_rd", readdata, 32'd2);
      tick();

      // "Hi!" then drain
      for (int i = 0; i < 3; i++) cyc(1, c_TX, {24'h0, hi[i]}, 0, 0);
      drive(0, c_ST, 0, 0, 0);
      check("st_hi", readdata, 32'h0000_0300);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, c_ST, 0, 1, 0);
         check("hi_byte", {24'h0, tx_data}, {24'h0, hi[i]});
         tick();
      end
      drive(0, 32'd84, 0, 1, 0);
      check("hi_done", {31'h0, tx_valid}, 32'h0);
      tick();

      // Overflow
      for (int i = 0; i < 9; i++) cyc(1, c_TX, i, 0, 0);
      drive(0, c_ST, 0, 0, 0);
      check("st_ovf", readdata, 32'h0000_0806);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(0, c_ST, 0, 1, 0);
         check("ovf_byte", {24'h0, tx_data}, i);
         tick();
      end
      drive(0, c_ST, 0, 1, 0);
      check("st_ovf_kept", readdata, 32'h0000_0005);
      tick();

      // Push into a full FIFO while popping
      cyc(0, c_ST, 0, 0, 1);
      for (int i = 0; i < 8; i++) cyc(1, c_TX, 32'h10 + i, 0, 0);
      cyc(1, c_TX, 32'hAA, 1, 0);
      drive(0, c_ST, 0, 0, 0);
      check("st_full_pp", readdata, 32'h0000_0802);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(0, c_ST, 0, 1, 0);
         check("pp_byte", {24'h0, tx_data}, (i == 7) ? 32'hAA : 32'h11 + i);
         tick();
      end

      // Reset mid-drain with concurrent push, then halt
      for (int i = 0; i < 3; i++) cyc(1, c_TX, 32'h30 + i, 0, 0);
      cyc(0, c_ST, 0, 1, 0);
      cyc(0, c_ST, 0, 0, 0);
      cyc(1, c_TX, 32'h55, 1, 1);
      drive(0, c_ST, 0, 1, 0);
      check("rst_mid_txv", {31'h0, tx_valid}, 32'h0);
      check("rst_mid_st", readdata, 32'h0000_0001);
      tick();
      cyc(1, c_HLT, 32'h0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 32'd16 * i, i, 1, 0);
      drive(0, c_ST, 0, 1, 0);
      check("halt_set", {31'h0, halt}, 32'h1);
      check("st_halt", readdata, 32'h0000_0009);
      tick();
      cyc(0, c_HLT, 0, 1, 1);
      drive(0, c_HLT, 0, 1, 0);
      check("halt_clr", readdata, 32'h0);
      tick();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) < 35)
            a = c_BASE | ($urandom_range(0, 3) << 2);
         else
            a = {$urandom() & 32'h00FF_FFFF} & ~32'h3;
         cyc(($urandom_range(0, 99) < (a[31:4] == c_BASE[31:4] && a[3:2] == 2'd2 ? 5 : 55)),
             a, $urandom(), $urandom_range(0, 1), ($urandom_range(0, 99) < 2));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
